// File: rtl/scaled_video_display_reader.sv
// Display-side reader: raster timing, centred-window FIFO reads,
// background fill, per-frame output-FIFO reset and display vsync.
//
// Ports:
//   output_clk, sys_rst_n    pixel clock, async active-low reset
//   i_dst_w, i_dst_h         destination window size (latched per frame)
//   o_data_req               FIFO rd_en; i_data valid one cycle later
//   i_data, i_fifo_empty     FIFO read data and empty flag
//   o_fifo_o_rst             output-FIFO reset pulse (line V_ACTIVE)
//   o_disp_vsync             vsync to the processing controller
//   o_hs, o_vs, o_de, o_rgb  display timing and pixel, mutually aligned
//   o_underflow              sticky per frame: request issued while empty
module scaled_video_display_reader #(
    parameter int DATA_CHANNEL = 3,
    parameter int IMAGE_WIDTH  = 11,
    parameter int H_ACTIVE     = 1920,
    parameter int H_FP         = 88,
    parameter int H_SYNC       = 44,
    parameter int H_BP         = 148,
    parameter int V_ACTIVE     = 1080,
    parameter int V_FP         = 4,
    parameter int V_SYNC       = 5,
    parameter int V_BP         = 36,
    parameter logic [8*DATA_CHANNEL-1:0] BG_COLOR = '0,
    parameter int RST_CYCLES   = 16
) (
    input  logic                      output_clk,
    input  logic                      sys_rst_n,
    input  logic [IMAGE_WIDTH-1:0]    i_dst_w,
    input  logic [IMAGE_WIDTH-1:0]    i_dst_h,
    output logic                      o_data_req,
    input  logic [8*DATA_CHANNEL-1:0] i_data,
    input  logic                      i_fifo_empty,
    output logic                      o_fifo_o_rst,
    output logic                      o_disp_vsync,
    output logic                      o_hs,
    output logic                      o_vs,
    output logic                      o_de,
    output logic [8*DATA_CHANNEL-1:0] o_rgb,
    output logic                      o_underflow
);

    localparam int CW      = 12;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] HA     = CW'(H_ACTIVE);
    localparam logic [CW-1:0] VA     = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] RST_N  = CW'(RST_CYCLES);

    logic [CW-1:0] h_cnt, v_cnt;
    logic [CW-1:0] h_nxt, v_nxt;

    logic [CW-1:0] w_in, h_in, w_clamp, h_clamp;
    logic [CW-1:0] x0_new, y0_new;
    logic [CW-1:0] w_q, h_q, x0_q, y0_q;
    logic [CW-1:0] w_eff, h_eff, x0_eff, y0_eff;

    logic frame_start, in_win, de_t, hs_t, vs_t;
    logic fifo_rst_d, armed;

    logic de_a, hs_a, vs_a;
    logic req_d, ok_d, de_d, hs_d, vs_d;

    always_comb begin
        h_nxt = h_cnt + CW'(1);
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
        end
    end

    assign frame_start = (h_cnt == '0) && (v_cnt == '0);

    assign w_in    = CW'(i_dst_w);
    assign h_in    = CW'(i_dst_h);
    assign w_clamp = (w_in > HA) ? HA : w_in;
    assign h_clamp = (h_in > VA) ? VA : h_in;
    assign x0_new  = (HA - w_clamp) >> 1;
    assign y0_new  = (VA - h_clamp) >> 1;

    // New geometry already applies in the frame-start cycle.
    assign w_eff  = frame_start ? w_clamp : w_q;
    assign h_eff  = frame_start ? h_clamp : h_q;
    assign x0_eff = frame_start ? x0_new  : x0_q;
    assign y0_eff = frame_start ? y0_new  : y0_q;

    assign in_win = (h_cnt >= x0_eff) && (h_cnt < x0_eff + w_eff)
                 && (v_cnt >= y0_eff) && (v_cnt < y0_eff + h_eff);

    assign de_t = (h_cnt < HA) && (v_cnt < VA);
    assign hs_t = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_t = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

    // Pulse is decoded from the next count so it lines up with the
    // counter cycles (0..RST_CYCLES-1, V_ACTIVE).
    assign fifo_rst_d = (v_nxt == VA) && (h_nxt < RST_N);

    assign o_disp_vsync = vs_a;

    always_ff @(posedge output_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    always_ff @(posedge output_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            w_q  <= '0;
            h_q  <= '0;
            x0_q <= '0;
            y0_q <= '0;
        end else if (frame_start) begin
            w_q  <= w_clamp;
            h_q  <= h_clamp;
            x0_q <= x0_new;
            y0_q <= y0_new;
        end
    end

    always_ff @(posedge output_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            o_fifo_o_rst <= 1'b0;
            armed        <= 1'b0;
        end else begin
            o_fifo_o_rst <= fifo_rst_d;
            if (o_fifo_o_rst && !fifo_rst_d) begin
                armed <= 1'b1;
            end
        end
    end

    // Stage A: request and timing, one cycle after the counters.
    always_ff @(posedge output_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            o_data_req <= 1'b0;
            de_a       <= 1'b0;
            hs_a       <= 1'b0;
            vs_a       <= 1'b0;
        end else begin
            o_data_req <= in_win && armed;
            de_a       <= de_t;
            hs_a       <= hs_t;
            vs_a       <= vs_t;
        end
    end

    always_ff @(posedge output_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            o_underflow <= 1'b0;
        end else if (frame_start) begin
            o_underflow <= 1'b0;
        end else if (o_data_req && i_fifo_empty) begin
            o_underflow <= 1'b1;
        end
    end

    // Stage A delayed to meet the FIFO read latency.
    always_ff @(posedge output_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            req_d <= 1'b0;
            ok_d  <= 1'b0;
            de_d  <= 1'b0;
            hs_d  <= 1'b0;
            vs_d  <= 1'b0;
        end else begin
            req_d <= o_data_req;
            ok_d  <= o_data_req && !i_fifo_empty;
            de_d  <= de_a;
            hs_d  <= hs_a;
            vs_d  <= vs_a;
        end
    end

    // Stage B: i_data belongs to the request two cycles back; an
    // underflowed request shows background instead of stale data.
    always_ff @(posedge output_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            o_de  <= 1'b0;
            o_hs  <= 1'b0;
            o_vs  <= 1'b0;
            o_rgb <= '0;
        end else begin
            o_de  <= de_d;
            o_hs  <= hs_d;
            o_vs  <= vs_d;
            o_rgb <= (req_d && ok_d) ? i_data : BG_COLOR;
        end
    end

endmodule

// File: tb/tb_scaled_video_display_reader.sv
// Bench for scaled_video_display_reader: small display mode, FIFO
// model with incrementing data, per-cycle model compare plus frame tallies.
module tb_scaled_video_display_reader;

    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 2;
    localparam int HB = 2;
    localparam int VA = 8;
    localparam int VF = 1;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int RC = 4;
    localparam int M  = 4095;
    localparam logic [23:0] BG   = 24'h102030;
    localparam logic [23:0] JUNK = 24'hEEEEEE;

    logic        output_clk = 1'b0;
    logic        sys_rst_n  = 1'b1;
    logic [10:0] i_dst_w    = 11'd8;
    logic [10:0] i_dst_h    = 11'd4;
    logic        o_data_req;
    logic [23:0] i_data     = JUNK;
    logic        i_fifo_empty = 1'b0;
    logic        o_fifo_o_rst;
    logic        o_disp_vsync;
    logic        o_hs;
    logic        o_vs;
    logic        o_de;
    logic [23:0] o_rgb;
    logic        o_underflow;

    scaled_video_display_reader #(
        .DATA_CHANNEL(3),
        .IMAGE_WIDTH (11),
        .H_ACTIVE    (HA),
        .H_FP        (HF),
        .H_SYNC      (HS),
        .H_BP        (HB),
        .V_ACTIVE    (VA),
        .V_FP        (VF),
        .V_SYNC      (VS),
        .V_BP        (VB),
        .BG_COLOR    (BG),
        .RST_CYCLES  (RC)
    ) dut (
        .output_clk  (output_clk),
        .sys_rst_n   (sys_rst_n),
        .i_dst_w     (i_dst_w),
        .i_dst_h     (i_dst_h),
        .o_data_req  (o_data_req),
        .i_data      (i_data),
        .i_fifo_empty(i_fifo_empty),
        .o_fifo_o_rst(o_fifo_o_rst),
        .o_disp_vsync(o_disp_vsync),
        .o_hs        (o_hs),
        .o_vs        (o_vs),
        .o_de        (o_de),
        .o_rgb       (o_rgb),
        .o_underflow (o_underflow)
    );

    always #5 output_clk = ~output_clk;

    int checks = 0;
    int errors = 0;

    // Model state: time index since reset release, raster position,
    // frame geometry, arm/underflow flags and FIFO pop counter.
    int c, mh, mv;
    int lw, lh, lx0, ly0;
    bit m_armed, m_uf;
    int m_reqno, force_idx;
    logic [23:0] fifo_next;

    bit reqt [0:M];
    bit vst  [0:M];
    bit hst  [0:M];
    bit det  [0:M];
    bit good [0:M];
    logic [23:0] dat [0:M];

    int n_req, n_de, n_bg, n_rst;
    bit seen_px;
    logic [23:0] first_px;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h",
                     nm, c, act, exp);
        end
    endtask

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic cycle_work();
        bit ro, emp, fs;
        logic [23:0] erg;
        ro = (c >= 1) ? reqt[(c-1) & M] : 1'b0;
        if (c == 0) erg = 24'h0;
        else if (c >= 2 && good[(c-2) & M]) erg = dat[(c-1) & M];
        else erg = BG;

        chk("fifo_o_rst", 32'(o_fifo_o_rst), 32'(mv == VA && mh < RC));
        chk("data_req", 32'(o_data_req), 32'(ro));
        chk("disp_vsync", 32'(o_disp_vsync),
            32'((c >= 1) ? vst[(c-1) & M] : 1'b0));
        chk("de", 32'(o_de), 32'((c >= 3) ? det[(c-3) & M] : 1'b0));
        chk("hs", 32'(o_hs), 32'((c >= 3) ? hst[(c-3) & M] : 1'b0));
        chk("vs", 32'(o_vs), 32'((c >= 3) ? vst[(c-3) & M] : 1'b0));
        chk("rgb", 32'(o_rgb), 32'(erg));
        chk("underflow", 32'(o_underflow), 32'(m_uf));

        if (o_data_req) n_req++;
        if (o_de) n_de++;
        if (o_de && o_rgb == BG) n_bg++;
        if (o_fifo_o_rst) n_rst++;
        if (o_de && o_rgb != BG && !seen_px) begin
            seen_px  = 1'b1;
            first_px = o_rgb;
        end

        fs = (mh == 0) && (mv == 0);
        if (fs) m_reqno = 0;
        emp = ro && (m_reqno == force_idx);
        if (ro) m_reqno++;
        i_fifo_empty = emp;
        good[c & M] = ro && !emp;
        if (c >= 1 && good[(c-1) & M]) begin
            dat[c & M] = fifo_next;
            fifo_next  = fifo_next + 24'd1;
        end else begin
            dat[c & M] = JUNK;
        end
        i_data = dat[c & M];
        m_uf = fs ? 1'b0 : (m_uf | (ro && emp));

        if (mh == RC && mv == VA) m_armed = 1'b1;
        if (fs) begin
            lw  = imin(int'(i_dst_w), HA);
            lh  = imin(int'(i_dst_h), VA);
            lx0 = (HA - lw) / 2;
            ly0 = (VA - lh) / 2;
        end
        reqt[c & M] = m_armed && mh >= lx0 && mh < lx0 + lw
                   && mv >= ly0 && mv < ly0 + lh;
        det[c & M] = (mh < HA) && (mv < VA);
        hst[c & M] = (mh >= HA + HF) && (mh < HA + HF + HS);
        vst[c & M] = (mv >= VA + VF) && (mv < VA + VF + VS);

        mh++;
        if (mh == HT) begin
            mh = 0;
            mv++;
            if (mv == VT) mv = 0;
        end
        c++;
    endtask

    task automatic run(int n);
        repeat (n) begin
            @(negedge output_clk);
            cycle_work();
        end
    endtask

    task automatic do_reset(int hold);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("rst req", 32'(o_data_req), 32'd0);
        chk("rst fifo_rst", 32'(o_fifo_o_rst), 32'd0);
        chk("rst vsync", 32'(o_disp_vsync), 32'd0);
        chk("rst hs", 32'(o_hs), 32'd0);
        chk("rst vs", 32'(o_vs), 32'd0);
        chk("rst de", 32'(o_de), 32'd0);
        chk("rst rgb", 32'(o_rgb), 32'd0);
        chk("rst uf", 32'(o_underflow), 32'd0);
        repeat (hold) @(negedge output_clk);
        sys_rst_n = 1'b1;
        c = 0; mh = 0; mv = 0;
        m_armed = 1'b0; m_uf = 1'b0; m_reqno = 0;
        lw = 0; lh = 0; lx0 = 0; ly0 = 0;
        fifo_next = 24'h000100;
        n_req = 0; n_de = 0; n_bg = 0; n_rst = 0;
        seen_px = 1'b0; first_px = 24'h0;
        cycle_work();
    endtask

    task automatic frame_check(string nm, int er, int ebg);
        chk({nm, " reqs"}, 32'(n_req), 32'(er));
        chk({nm, " de"}, 32'(n_de), 32'd128);
        chk({nm, " bg"}, 32'(n_bg), 32'(ebg));
        chk({nm, " rst"}, 32'(n_rst), 32'(RC));
        n_req = 0; n_de = 0; n_bg = 0; n_rst = 0;
    endtask

    initial begin
        force_idx = -1;
        i_dst_w = 11'd8;
        i_dst_h = 11'd4;
        do_reset(3);
        run(FR - 1);
        frame_check("f0", 0, 128);

        run(FR);
        frame_check("f1", 32, 96);
        chk("first_px", 32'(first_px), 32'h000100);

        i_dst_w = 11'd20;
        i_dst_h = 11'd10;
        run(FR);
        frame_check("clamp", 128, 0);

        i_dst_w = 11'd0;
        i_dst_h = 11'd4;
        run(FR);
        frame_check("zero_w", 0, 128);

        i_dst_w = 11'd8;
        run(121);
        i_dst_w = 11'd6;
        run(FR - 121);
        frame_check("w8", 32, 96);
        run(FR);
        frame_check("w6", 24, 104);

        i_dst_w = 11'd8;
        force_idx = 4;
        run(FR);
        frame_check("uf", 32, 97);
        chk("uf_hold", 32'(o_underflow), 32'd1);
        force_idx = -1;
        run(2);
        chk("uf_clr", 32'(o_underflow), 32'd0);
        run(FR - 2);
        frame_check("after_uf", 32, 96);

        run(3 * HT + 6);
        chk("pre_rst req", 32'(o_data_req), 32'd1);
        do_reset(3);
        run(FR - 1);
        frame_check("rst0", 0, 128);
        run(FR);
        frame_check("rearm", 32, 96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scaled_video_display_reader.md
# scaled_video_display_reader

Display-side consumer of the scaler's output FIFO, clocked on output_clk. Generates raster timing (hsync/vsync/de) for a fixed display mode and issues FIFO read requests for a destination window of i_dst_w × i_dst_h centred in the active area. Fills pixels outside that window with a background colour. Drives the per-frame output-FIFO reset and the display vsync that restarts the processing chain.

## Interface
Parameters:
- DATA_CHANNEL, 3, colour channels (8 bits each)
- IMAGE_WIDTH, 11, width of dst size inputs
- H_ACTIVE / H_FP / H_SYNC / H_BP, 1920 / 88 / 44 / 148, horizontal timing in pixels
- V_ACTIVE / V_FP / V_SYNC / V_BP, 1080 / 4 / 5 / 36, vertical timing in lines; V_FP ≥ 1
- BG_COLOR, 0, background pixel value, 8*DATA_CHANNEL bits
- RST_CYCLES, 16, o_fifo_o_rst pulse length, ≤ H_TOTAL

Ports:
- output_clk  in  1  pixel clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- i_dst_w  in  IMAGE_WIDTH  destination width
- i_dst_h  in  IMAGE_WIDTH  destination height
- o_data_req  out  1  FIFO rd_en
- i_data  in  8*DATA_CHANNEL  FIFO rd_data, valid 1 cycle after o_data_req
- i_fifo_empty  in  1  FIFO empty (AND of channel empties)
- o_fifo_o_rst  out  1  output-FIFO reset pulse
- o_disp_vsync  out  1  vsync to processing controller
- o_hs / o_vs / o_de  out  1  display sync/enable, active-high
- o_rgb  out  8*DATA_CHANNEL  display pixel
- o_underflow  out  1  sticky: request issued while FIFO empty this frame

## Operation
- Counters: h_cnt in 0..H_TOTAL-1, v_cnt in 0..V_TOTAL-1. H_TOTAL = sum of the four H params; V_TOTAL likewise. Counter width is 12 bits. h_cnt wraps to 0 and increments v_cnt; v_cnt wraps at V_TOTAL-1.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- hs: h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vs: v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Frame start is (h_cnt,v_cnt)=(0,0). At frame start, latch:
  - w = min(i_dst_w, H_ACTIVE), h = min(i_dst_h, V_ACTIVE)
  - x0 = (H_ACTIVE−w)>>1, y0 = (V_ACTIVE−h)>>1 (floor)
  - Inputs are ignored at all other times.
- Window: x0 ≤ h_cnt < x0+w and y0 ≤ v_cnt < y0+h. w=0 or h=0 gives an empty window: no requests.
- Request: o_data_req = window AND armed. It is issued for every window pixel regardless of i_fifo_empty, so the pixel count stays exact.
- Underflow:
  - If o_data_req is high and i_fifo_empty is high in the same cycle, set o_underflow.
  - That pixel outputs BG_COLOR.
  - o_underflow clears at frame start.
- FIFO reset:
  - o_fifo_o_rst goes high for RST_CYCLES cycles, starting when (h_cnt,v_cnt)=(0,V_ACTIVE).
  - The `armed` flag sets on the falling edge of o_fifo_o_rst.
  - After reset, armed=0, so the first partial frame shows only BG_COLOR and issues no requests.
- o_disp_vsync equals the stage-A registered vs.
- Pixel mux: o_rgb = i_data when the twice-delayed request is high and was not underflowed. Otherwise o_rgb = BG_COLOR (outside the window, and during blanking).

## Timing
- Pipeline:
  - Cycle t: counters.
  - t+1, stage A (registered): o_data_req, de_a, hs_a, vs_a, o_disp_vsync.
  - t+2: FIFO data valid on i_data. Stage A is delayed one cycle.
  - t+3, stage B (registered): o_de, o_hs, o_vs, o_rgb.
- o_data_req leads the o_de cycle carrying its pixel by exactly 2 cycles.
- o_hs, o_vs, o_de and o_rgb are mutually aligned.
- Latched w/h/x0/y0 take effect from the frame-start cycle itself.
- Reset (asynchronous, including mid-frame):
  - Counters, all pipeline registers, armed and o_underflow go to 0.
  - o_rgb = 0 (not BG_COLOR).
  - o_fifo_o_rst = 0.
  - After release, counting resumes at (0,0).
- o_fifo_o_rst completes within line V_ACTIVE, before vs rises, because V_FP ≥ 1.

## Test plan
All scenarios use H 16/2/2/2, V 8/1/1/1, BG_COLOR=0x102030, RST_CYCLES=4.
- Reset release, dst 8×4: frame 0 has zero requests and o_rgb=0x102030 during de. o_fifo_o_rst is high for 4 cycles from (0,8). armed sets.
- Frame 1, dst 8×4, FIFO model holding an incrementing pattern:
  - Exactly 32 requests, at h_cnt 4..11 on lines 2..5.
  - o_rgb during de equals the FIFO data at x 4..11, y 2..5; elsewhere 0x102030.
  - o_de is high 128 cycles; o_data_req leads by 2.
- dst 20×10: clamped to 16×8, 128 requests covering the full active area. dst 0×4: zero requests.
- i_dst_w changes from 8 to 6 mid-frame: the current frame keeps 8/line. The next frame uses x0=5 and 6/line.
- i_fifo_empty forced high for one request:
  - That pixel outputs 0x102030 and o_underflow=1.
  - o_underflow stays high until the next frame start, then clears.
- sys_rst_n asserted mid-window:
  - All outputs are 0 immediately.
  - After release, frame 0 has no requests and the next FIFO-reset pulse re-arms.
